// File: rtl/compression_lane_dispatcher.sv
// Packet-level round-robin dispatcher from one AXI-Stream source to N compressor lanes, with an order-tag FIFO.
// Optional per-lane packet and stall counters are enabled by defining DISPATCH_STATS_EN.
module compression_lane_dispatcher #(
  parameter int N_LANES     = 4,
  parameter int DATA_BITS   = 512,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic [DATA_BITS-1:0]         s_tdata,
  input  logic [DATA_BITS/8-1:0]       s_tkeep,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [DATA_BITS-1:0]         m_tdata,
  output logic [DATA_BITS/8-1:0]       m_tkeep,
  output logic                         m_tlast,
  output logic [N_LANES-1:0]           m_tvalid,
  input  logic [N_LANES-1:0]           m_tready,
  input  logic [N_LANES-1:0]           lane_busy,
  output logic [$clog2(N_LANES)-1:0]   ord_lane,
  output logic                         ord_valid,
  input  logic                         ord_ready
`ifdef DISPATCH_STATS_EN
  ,
  output logic [N_LANES*32-1:0]        stat_pkts,
  output logic [31:0]                  stat_stall
`endif
);

  localparam int LW = $clog2(N_LANES);
  localparam int AW = $clog2(ORDER_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t          state_r, state_nxt;
  logic [LW-1:0]   ptr_r, lane_r, gnt_lane;
  logic            found, grant, pop, full, last_hs;
  logic [LW-1:0]   fifo_mem [ORDER_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;

  function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int step);
    return LW'((int'(base) + step) % N_LANES);
  endfunction

  assign m_tdata   = s_tdata;
  assign m_tkeep   = s_tkeep;
  assign m_tlast   = s_tlast;
  assign ord_valid = (count_r != '0);
  assign ord_lane  = fifo_mem[rd_ptr_r];
  assign full      = (count_r == (AW+1)'(ORDER_DEPTH));
  assign pop       = ord_valid & ord_ready;

  // Round-robin search: first non-busy lane upward from ptr+1
  always_comb begin
    found    = 1'b0;
    gnt_lane = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      if (!found && !lane_busy[wrap_add(ptr_r, k)]) begin
        found    = 1'b1;
        gnt_lane = wrap_add(ptr_r, k);
      end
    end
  end

  // Next-state and lane steering
  always_comb begin
    state_nxt = state_r;
    m_tvalid  = '0;
    s_tready  = 1'b0;
    grant     = 1'b0;
    last_hs   = 1'b0;
    case (state_r)
      IDLE: begin
        grant = s_tvalid & enable & found & ~full;
        if (grant) state_nxt = STREAM;
        else       state_nxt = IDLE;
      end
      STREAM: begin
        m_tvalid[lane_r] = s_tvalid;
        s_tready         = m_tready[lane_r];
        last_hs          = s_tvalid & m_tready[lane_r] & s_tlast;
        if (last_hs) state_nxt = IDLE;
        else         state_nxt = STREAM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, RR pointer and granted lane registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      ptr_r   <= LW'(N_LANES - 1);
      lane_r  <= '0;
    end else begin
      state_r <= state_nxt;
      if (grant) begin
        ptr_r  <= gnt_lane;
        lane_r <= gnt_lane;
      end
    end
  end

  // Order FIFO pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (grant) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({grant, pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Order FIFO storage; contents are don't-care while empty
  always_ff @(posedge aclk) begin
    if (grant) fifo_mem[wr_ptr_r] <= gnt_lane;
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] pkts_r [N_LANES];
  logic [31:0] stall_r;

  // Per-lane completed-packet counters and IDLE stall counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_LANES; i++) pkts_r[i] <= 32'd0;
      stall_r <= 32'd0;
    end else begin
      if (last_hs) pkts_r[lane_r] <= pkts_r[lane_r] + 32'd1;
      if ((state_r == IDLE) && s_tvalid && enable && !grant) stall_r <= stall_r + 32'd1;
    end
  end

  // Flatten lane counters onto the output bus
  always_comb begin
    stat_pkts = '0;
    for (int i = 0; i < N_LANES; i++) stat_pkts[32*i +: 32] = pkts_r[i];
  end

  assign stat_stall = stall_r;
`endif

endmodule

// File: tb/tb_compression_lane_dispatcher.sv
// Self-checking bench for compression_lane_dispatcher: directed scenarios plus random traffic
// compared cycle by cycle against a packet-level reference model.
module tb_compression_lane_dispatcher;

  localparam int NL = 4;
  localparam int DB = 512;
  localparam int OD = 16;

  logic            aclk = 1'b0;
  logic            aresetn, enable, s_tlast, s_tvalid, ord_ready;
  logic [DB-1:0]   s_tdata;
  logic [DB/8-1:0] s_tkeep;
  logic [NL-1:0]   m_tready, lane_busy;
  logic            s_tready, m_tlast, ord_valid;
  logic [DB-1:0]   m_tdata;
  logic [DB/8-1:0] m_tkeep;
  logic [NL-1:0]   m_tvalid;
  logic [1:0]      ord_lane;
`ifdef DISPATCH_STATS_EN
  logic [NL*32-1:0] stat_pkts;
  logic [31:0]      stat_stall;
`endif

  compression_lane_dispatcher #(.N_LANES(NL), .DATA_BITS(DB), .ORDER_DEPTH(OD)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .lane_busy(lane_busy), .ord_lane(ord_lane), .ord_valid(ord_valid), .ord_ready(ord_ready)
`ifdef DISPATCH_STATS_EN
    , .stat_pkts(stat_pkts), .stat_stall(stat_stall)
`endif
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: packet in flight, its lane, RR pointer, tag queue, stats
  bit in_pkt;
  int cur_lane, ptr, stall;
  int q[$];
  int pkts[NL];
  int hs_cnt;
  logic [NL-1:0] seen_v;

  task automatic check_value(input string tag, input logic [DB-1:0] actual, input logic [DB-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    in_pkt = 1'b0; cur_lane = 0; ptr = NL - 1; stall = 0;
    q.delete();
    for (int i = 0; i < NL; i++) pkts[i] = 0;
  endtask

  task automatic compare_outputs();
    logic [NL-1:0] exp_v;
    logic          exp_r;
    exp_v = '0;
    exp_r = 1'b0;
    if (in_pkt) begin
      exp_v[cur_lane] = s_tvalid;
      exp_r = m_tready[cur_lane];
    end
    check_value("m_tvalid", DB'(m_tvalid), DB'(exp_v));
    check_value("s_tready", DB'(s_tready), DB'(exp_r));
    check_value("ord_valid", DB'(ord_valid), DB'(q.size() != 0));
    if (q.size() != 0) check_value("ord_lane", DB'(ord_lane), DB'(q[0]));
    check_value("m_tdata", m_tdata, s_tdata);
    check_value("m_tkeep", DB'(m_tkeep), DB'(s_tkeep));
    check_value("m_tlast", DB'(m_tlast), DB'(s_tlast));
`ifdef DISPATCH_STATS_EN
    for (int i = 0; i < NL; i++) check_value("stat_pkts", DB'(stat_pkts[32*i +: 32]), DB'(pkts[i]));
    check_value("stat_stall", DB'(stat_stall), DB'(stall));
`endif
    if (s_tvalid && s_tready) hs_cnt++;
    seen_v |= m_tvalid;
  endtask

  // Advance the packet-level model by one clock using the inputs held this cycle
  task automatic model_clock();
    bit do_pop;
    int g;
    do_pop = (q.size() != 0) && ord_ready;
    g = -1;
    if (!in_pkt) begin
      if (s_tvalid && enable) begin
        if (q.size() < OD)
          for (int k = 1; k <= NL; k++)
            if (g < 0 && !lane_busy[(ptr + k) % NL]) g = (ptr + k) % NL;
        if (g >= 0) begin in_pkt = 1'b1; cur_lane = g; ptr = g; end
        else stall++;
      end
    end else if (s_tvalid && m_tready[cur_lane] && s_tlast) begin
      in_pkt = 1'b0;
      pkts[cur_lane]++;
    end
    if (do_pop) void'(q.pop_front());
    if (g >= 0) q.push_back(g);
  endtask

  task automatic step();
    #1;
    compare_outputs();
    @(posedge aclk);
    model_clock();
    @(negedge aclk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < DB/32; i++) s_tdata[32*i +: 32] = $urandom;
    s_tkeep = {$urandom, $urandom};
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    #1;
    check_value("rst_m_tvalid", DB'(m_tvalid), DB'(0));
    check_value("rst_s_tready", DB'(s_tready), DB'(0));
    check_value("rst_ord_valid", DB'(ord_valid), DB'(0));
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    hs_cnt = 0;
    seen_v = '0;
  endtask

  task automatic send_one_beat(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      s_tvalid = 1'b1; s_tlast = 1'b1; rand_data();
      step();
    end
  endtask

  initial begin
    aresetn = 1'b1; enable = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; ord_ready = 1'b0;
    s_tdata = '0; s_tkeep = '0; m_tready = '1; lane_busy = '0;
    hs_cnt = 0; seen_v = '0;
    model_reset();
    #2;
    apply_reset();

    // Four back-to-back packets go to lanes 0..3, two cycles each
    send_one_beat(8);
    check_value("t1_handshakes", DB'(hs_cnt), DB'(4));
    s_tvalid = 1'b0; ord_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_value("t1_ord_lane", DB'(ord_lane), DB'(k));
      step();
    end

    // Lane 1 busy: lanes 0,2,3 only
    apply_reset();
    lane_busy = 4'b0010;
    send_one_beat(6);
    check_value("t2_lanes_seen", DB'(seen_v), DB'(4'b1101));
    lane_busy = '0;

    // Order FIFO full stalls the 17th packet until one tag pops
    apply_reset();
    ord_ready = 1'b0;
    send_one_beat(40);
    check_value("t3_dispatched", DB'(hs_cnt), DB'(16));
    #1;
    check_value("t3_stalled_ready", DB'(s_tready), DB'(0));
    ord_ready = 1'b1;
    step();
    ord_ready = 1'b0;
    send_one_beat(2);
    check_value("t3_after_pop", DB'(hs_cnt), DB'(17));
    s_tvalid = 1'b0;

    // Three-beat packet with lane backpressure after beat 1
    apply_reset();
    ord_ready = 1'b1;
    s_tvalid = 1'b1; s_tlast = 1'b0; rand_data(); step();
    step();
    rand_data(); m_tready = 4'b1110; step(); step();
    m_tready = '1; step();
    s_tlast = 1'b1; rand_data(); step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    check_value("t4_beats", DB'(hs_cnt), DB'(3));
    check_value("t4_idle_valid", DB'(m_tvalid), DB'(0));
    step();

    // Async reset during beat 2 on lane 2, then next packet to lane 0
    apply_reset();
    send_one_beat(4);
    s_tvalid = 1'b1; s_tlast = 1'b0; rand_data(); step();
    step();
    rand_data();
    #1;
    check_value("t5_on_lane2", DB'(m_tvalid), DB'(4'b0100));
    #1;
    apply_reset();
    s_tvalid = 1'b1; s_tlast = 1'b1; rand_data(); step();
    #1;
    check_value("t5_lane0_after_rst", DB'(m_tvalid), DB'(4'b0001));
    step();
    s_tvalid = 1'b0;

`ifdef DISPATCH_STATS_EN
    // Stats: five packets on lane 0, then seven stalled cycles
    apply_reset();
    lane_busy = 4'b1110;
    send_one_beat(10);
    check_value("t6_pkts_lane0", DB'(stat_pkts[31:0]), DB'(5));
    check_value("t6_pkts_others", DB'(stat_pkts[127:32]), DB'(0));
    lane_busy = 4'b1111;
    send_one_beat(7);
    s_tvalid = 1'b0;
    #1;
    check_value("t6_stall", DB'(stat_stall), DB'(7));
    step();
    lane_busy = '0;
`endif

    // Random traffic against the model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tlast   = ($urandom_range(0, 2) == 0);
      enable    = ($urandom_range(0, 4) != 0);
      ord_ready = ($urandom_range(0, 1) == 1);
      m_tready  = 4'($urandom) | 4'($urandom);
      lane_busy = 4'($urandom) & 4'($urandom);
      rand_data();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
